// File: rtl/video_stream_tx.sv
// Raster timing generator and registered RGB source fed by a valid/ready pixel stream with SOF alignment.
// Optional macro VIDEO_TX_UNDERFLOW_PATTERN_EN: starved active pixels show eight colour bars instead of black.
module video_stream_tx #(
   parameter int H_ACTIVE = 128,
   parameter int H_FRONT  = 4,
   parameter int H_SYNC   = 8,
   parameter int H_TOTAL  = 144,
   parameter int V_ACTIVE = 32,
   parameter int V_FRONT  = 2,
   parameter int V_SYNC   = 2,
   parameter int V_TOTAL  = 40,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_enable,
   input  logic        I_pix_valid,
   input  logic [23:0] I_pix_data,
   input  logic        I_pix_sof,
   output logic        O_pix_ready,
   output logic        O_rgb_vs,
   output logic        O_rgb_hs,
   output logic        O_rgb_de,
   output logic [7:0]  O_rgb_r,
   output logic [7:0]  O_rgb_g,
   output logic [7:0]  O_rgb_b,
   output logic        O_frame_start,
   output logic        O_underflow,
   output logic [15:0] O_underflow_cnt,
   output logic        O_resync
);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic          fs_q, fs_d, uf_q, uf_d, rs_q, rs_d;
   logic [15:0]   ucnt_q, ucnt_d;

   logic at_org, at_end, active, hs_win, vs_win;
   logic align, in_run, misalign, ready_run, take, starve, drop;

   assign at_org = (h_q == '0) && (v_q == '0);
   assign at_end = (int'(h_q) == H_TOTAL-1) && (int'(v_q) == V_TOTAL-1);
   assign active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
   assign hs_win = (int'(h_q) >= H_ACTIVE+H_FRONT) && (int'(h_q) < H_ACTIVE+H_FRONT+H_SYNC);
   assign vs_win = (int'(v_q) >= V_ACTIVE+V_FRONT) && (int'(v_q) < V_ACTIVE+V_FRONT+V_SYNC);

   // An SOF at the origin while aligning is consumed exactly like a running cycle.
   assign align     = (state_q == SYNC) && I_pix_valid && I_pix_sof && at_org;
   assign in_run    = (state_q == RUN) || align;
   assign misalign  = in_run && active && I_pix_valid && (I_pix_sof != at_org);
   assign ready_run = in_run && active && !misalign;
   assign take      = ready_run && I_pix_valid;
   assign starve    = in_run && active && !I_pix_valid;
   assign drop      = (state_q == SYNC) && I_pix_valid && !I_pix_sof;

   assign O_pix_ready = !I_rst && (ready_run || drop);

`ifdef VIDEO_TX_UNDERFLOW_PATTERN_EN
   logic [2:0]  bar_idx;
   logic [23:0] bar;
   // Bar order white..black maps to R=!idx[1], G=!idx[2], B=!idx[0].
   assign bar_idx = 3'(int'(h_q) / (H_ACTIVE/8));
   assign bar     = {{8{!bar_idx[1]}}, {8{!bar_idx[2]}}, {8{!bar_idx[0]}}};
`endif

   always_comb begin
      state_d = state_q;
      h_d     = '0;
      v_d     = '0;
      case (state_q)
         IDLE: if (I_enable) state_d = SYNC;
         SYNC, RUN: begin
            if (int'(h_q) == H_TOTAL-1) begin
               h_d = '0;
               v_d = (int'(v_q) == V_TOTAL-1) ? '0 : v_q + VW'(1);
            end else begin
               h_d = h_q + HW'(1);
               v_d = v_q;
            end
            if (misalign)   state_d = SYNC;
            else if (align) state_d = RUN;
            if (at_end && !I_enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      de_d   = in_run && active;
      hs_d   = ((state_q != IDLE) && hs_win) ? HS_POL : !HS_POL;
      vs_d   = ((state_q != IDLE) && vs_win) ? VS_POL : !VS_POL;
      fs_d   = take && at_org;
      uf_d   = starve;
      rs_d   = misalign;
      ucnt_d = (starve && (ucnt_q != 16'hFFFF)) ? ucnt_q + 16'd1 : ucnt_q;
      rgb_d  = '0;
      if (take) rgb_d = I_pix_data;
`ifdef VIDEO_TX_UNDERFLOW_PATTERN_EN
      else if (starve) rgb_d = bar;
`endif
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         rgb_q   <= '0;
         de_q    <= 1'b0;
         hs_q    <= !HS_POL;
         vs_q    <= !VS_POL;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
         rs_q    <= 1'b0;
         ucnt_q  <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         rgb_q   <= rgb_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
         rs_q    <= rs_d;
         ucnt_q  <= ucnt_d;
      end
   end

   assign O_rgb_r         = rgb_q[23:16];
   assign O_rgb_g         = rgb_q[15:8];
   assign O_rgb_b         = rgb_q[7:0];
   assign O_rgb_de        = de_q;
   assign O_rgb_hs        = hs_q;
   assign O_rgb_vs        = vs_q;
   assign O_frame_start   = fs_q;
   assign O_underflow     = uf_q;
   assign O_underflow_cnt = ucnt_q;
   assign O_resync        = rs_q;
endmodule

// File: tb/tb_video_stream_tx.sv
// Directed bench for video_stream_tx: default raster on one instance, a near-all-active raster for count saturation.
module tb_video_stream_tx;
   localparam int HT = 144;
   localparam int VT = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, pv, ps;
   logic [23:0] pd;
   logic        rdy, vs, hs, de, fs, uf, rs;
   logic [7:0]  r, g, b;
   logic [15:0] ucnt;
   logic [23:0] rgb;
   assign rgb = {r, g, b};

   video_stream_tx dut (
      .I_clk(clk), .I_rst(rst), .I_enable(en), .I_pix_valid(pv), .I_pix_data(pd), .I_pix_sof(ps),
      .O_pix_ready(rdy), .O_rgb_vs(vs), .O_rgb_hs(hs), .O_rgb_de(de),
      .O_rgb_r(r), .O_rgb_g(g), .O_rgb_b(b), .O_frame_start(fs),
      .O_underflow(uf), .O_underflow_cnt(ucnt), .O_resync(rs));

   logic        s_rst, s_en, s_pv, s_ps;
   logic [23:0] s_pd;
   logic        s_rdy, s_vs, s_hs, s_de, s_fs, s_uf, s_rs;
   logic [7:0]  s_r, s_g, s_b;
   logic [15:0] s_ucnt;

   video_stream_tx #(
      .H_ACTIVE(254), .H_FRONT(1), .H_SYNC(1), .H_TOTAL(256),
      .V_ACTIVE(254), .V_FRONT(1), .V_SYNC(1), .V_TOTAL(256)
   ) sat (
      .I_clk(clk), .I_rst(s_rst), .I_enable(s_en), .I_pix_valid(s_pv), .I_pix_data(s_pd), .I_pix_sof(s_ps),
      .O_pix_ready(s_rdy), .O_rgb_vs(s_vs), .O_rgb_hs(s_hs), .O_rgb_de(s_de),
      .O_rgb_r(s_r), .O_rgb_g(s_g), .O_rgb_b(s_b), .O_frame_start(s_fs),
      .O_underflow(s_uf), .O_underflow_cnt(s_ucnt), .O_resync(s_rs));

   int          tests = 0, fails = 0;
   int          h, v, ph, pvv, npix;
   logic        acc;
   logic [23:0] nd, cd;

   function automatic logic [23:0] starve_rgb(input int hp);
`ifdef VIDEO_TX_UNDERFLOW_PATTERN_EN
      case (hp / 16)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
`else
      return 24'h000000 + 24'(hp & 0);
`endif
   endfunction

   // One pixel-clock cycle: present the head, note acceptance, move past the edge; outputs then describe (ph,pvv).
   task automatic step(input logic vld, input logic sof);
      pv = vld; ps = sof; pd = nd;
      #2;
      acc = vld && rdy;
      cd = nd; ph = h; pvv = v;
      @(posedge clk); #1;
      if (acc) nd = nd + 24'h030507;
      if (h == HT-1) begin h = 0; v = (v == VT-1) ? 0 : v + 1; end
      else h = h + 1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      tests++; if ({de, hs, vs, fs, uf, rs, rgb, ucnt} !== 46'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {de, hs, vs, fs, uf, rs, rgb, ucnt}); end
      tests++; if (acc !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", acc); end
   endtask

   task automatic test_stream;
      int de_e = 0, acc_e = 0, dat_e = 0, hs_e = 0, vs_e = 0, fs_e = 0, fs_n = 0, rs_n = 0, uf_n = 0;
      logic xde, xhs, xvs;
      rst = 1'b0; en = 1'b0;
      step(1'b1, 1'b1);
      en = 1'b1;
      step(1'b1, 1'b1);
      tests++; if (acc !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b want 0", acc); end
      h = 0; v = 0; npix = 0;
      for (int i = 0; i < 2*HT*VT; i++) begin
         step(1'b1, (npix % 4096) == 0);
         if (acc) npix++;
         xde = (ph < 128) && (pvv < 32);
         xhs = (ph >= 132) && (ph < 140);
         xvs = (pvv >= 34) && (pvv < 36);
         if (de !== xde) de_e++;
         if (acc !== xde) acc_e++;
         if (xde && (rgb !== cd)) dat_e++;
         if (hs !== xhs) hs_e++;
         if (vs !== xvs) vs_e++;
         if (fs !== ((ph == 0) && (pvv == 0))) fs_e++;
         fs_n += int'(fs); rs_n += int'(rs); uf_n += int'(uf);
      end
      tests++; if (de_e != 0)  begin fails++; $display("FAIL t1_de: %0d bad cycles, want 0", de_e); end
      tests++; if (acc_e != 0) begin fails++; $display("FAIL t1_ready: %0d bad cycles, want 0", acc_e); end
      tests++; if (dat_e != 0) begin fails++; $display("FAIL t1_data: %0d bad pixels, want 0", dat_e); end
      tests++; if (hs_e != 0)  begin fails++; $display("FAIL t1_hs: %0d bad cycles, want 0", hs_e); end
      tests++; if (vs_e != 0)  begin fails++; $display("FAIL t1_vs: %0d bad cycles, want 0", vs_e); end
      tests++; if (fs_e != 0)  begin fails++; $display("FAIL t1_fs_pos: %0d bad cycles, want 0", fs_e); end
      tests++; if (fs_n != 2)  begin fails++; $display("FAIL t1_fs_count: got %0d want 2", fs_n); end
      tests++; if (rs_n + uf_n != 0) begin fails++; $display("FAIL t1_no_events: got %0d want 0", rs_n + uf_n); end
      tests++; if (npix != 8192) begin fails++; $display("FAIL t1_pixels: got %0d want 8192", npix); end
   endtask

   task automatic test_sof_search;
      int drop_n = 0, stall_n = 0, bad = 0, fs_n = 0, rs_n = 0;
      logic got = 1'b0;
      logic [23:0] sd;
      rst = 1'b1; step(1'b0, 1'b0);
      rst = 1'b0; step(1'b0, 1'b0);
      h = 0; v = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         drop_n += int'(acc); bad += int'(de); rs_n += int'(rs);
      end
      sd = nd;
      for (int i = 0; i < 6000; i++) begin
         step(1'b1, 1'b1);
         if (acc) begin got = 1'b1; break; end
         stall_n++; bad += int'(de); rs_n += int'(rs);
      end
      tests++; if (drop_n != 10) begin fails++; $display("FAIL t2_dropped: got %0d want 10", drop_n); end
      tests++; if (stall_n != 5750) begin fails++; $display("FAIL t2_stall: got %0d want 5750", stall_n); end
      tests++; if (!got || ph != 0 || pvv != 0) begin fails++; $display("FAIL t2_align: got %b at (%0d,%0d) want 1 at (0,0)", got, ph, pvv); end
      tests++; if ({de, rgb} !== {1'b1, sd}) begin fails++; $display("FAIL t2_first_pixel: got %h want %h", {de, rgb}, {1'b1, sd}); end
      fs_n += int'(fs);
      for (int i = 0; i < 300; i++) begin
         if (h == 0 && v == 1) break;
         step(1'b1, (h == 0) && (v == 0));
         fs_n += int'(fs); rs_n += int'(rs);
      end
      tests++; if (bad != 0)  begin fails++; $display("FAIL t2_de_in_sync: got %0d want 0", bad); end
      tests++; if (fs_n != 1) begin fails++; $display("FAIL t2_frame_start: got %0d want 1", fs_n); end
      tests++; if (rs_n != 0) begin fails++; $display("FAIL t2_resync: got %0d want 0", rs_n); end
   endtask

   task automatic test_underflow;
      int uf_n = 0, bad = 0, rs_n = 0;
      for (int i = 0; i < 300; i++) begin
         if (h == 60 && v == 1) break;
         step(1'b1, (h == 0) && (v == 0));
         uf_n += int'(uf); rs_n += int'(rs);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         if (uf !== 1'b1 || de !== 1'b1 || rgb !== starve_rgb(ph)) bad++;
         uf_n += int'(uf); rs_n += int'(rs);
      end
      for (int i = 0; i < 300; i++) begin
         if (h == 0 && v == 2) break;
         step(1'b1, (h == 0) && (v == 0));
         uf_n += int'(uf); rs_n += int'(rs);
      end
      tests++; if (bad != 0)     begin fails++; $display("FAIL t3_starved_px: %0d bad cycles, want 0", bad); end
      tests++; if (uf_n != 5)    begin fails++; $display("FAIL t3_pulses: got %0d want 5", uf_n); end
      tests++; if (ucnt !== 16'd5) begin fails++; $display("FAIL t3_count: got %0d want 5", ucnt); end
      tests++; if (rs_n != 0)    begin fails++; $display("FAIL t3_resync: got %0d want 0", rs_n); end
   endtask

   task automatic test_resync;
      int stall_n = 0, bad = 0;
      logic got = 1'b0;
      logic [23:0] x;
      for (int i = 0; i < 600; i++) begin
         if (h == 20 && v == 3) break;
         step(1'b1, (h == 0) && (v == 0));
      end
      x = nd;
      step(1'b1, 1'b1);
      tests++; if ({acc, rs, de, uf} !== 4'b0110) begin fails++; $display("FAIL t4_resync_cycle: got %b want 0110", {acc, rs, de, uf}); end
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL t4_black: got %h want 000000", rgb); end
      for (int i = 0; i < 6000; i++) begin
         step(1'b1, 1'b1);
         if (acc) begin got = 1'b1; break; end
         stall_n++; bad += int'(de) + int'(rs);
      end
      tests++; if (stall_n != 5307) begin fails++; $display("FAIL t4_stall: got %0d want 5307", stall_n); end
      tests++; if (bad != 0) begin fails++; $display("FAIL t4_sync_quiet: got %0d want 0", bad); end
      tests++; if (!got || ph != 0 || pvv != 0) begin fails++; $display("FAIL t4_realign: got %b at (%0d,%0d) want 1 at (0,0)", got, ph, pvv); end
      tests++; if ({de, fs, rgb} !== {2'b11, x}) begin fails++; $display("FAIL t4_first_pixel: got %h want %h", {de, fs, rgb}, {2'b11, x}); end
      tests++; if (ucnt !== 16'd5) begin fails++; $display("FAIL t4_count_kept: got %0d want 5", ucnt); end
   endtask

   task automatic test_stop;
      int bad = 0, idle_bad = 0;
      logic xde;
      for (int i = 0; i < 6000; i++) begin
         if (h == 0 && v == 10) en = 1'b0;
         if (h == 0 && v == 20) en = 1'b1;
         step(1'b1, (h == 0) && (v == 0));
         if (ph == HT-1 && pvv == VT-1) break;
      end
      step(1'b1, 1'b1);
      tests++; if (acc !== 1'b1) begin fails++; $display("FAIL t5_cancel: got %b want 1", acc); end
      for (int i = 0; i < 6000; i++) begin
         if (h == 0 && v == 10) en = 1'b0;
         step(1'b1, (h == 0) && (v == 0));
         xde = (ph < 128) && (pvv < 32);
         if (de !== xde || acc !== xde) bad++;
         if (ph == HT-1 && pvv == VT-1) break;
      end
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1);
         if (acc || de || hs || vs) idle_bad++;
      end
      tests++; if (bad != 0)      begin fails++; $display("FAIL t5_frame_completes: %0d bad cycles, want 0", bad); end
      tests++; if (idle_bad != 0) begin fails++; $display("FAIL t5_idle: %0d active cycles, want 0", idle_bad); end
   endtask

   task automatic test_reset_mid;
      en = 1'b1;
      step(1'b0, 1'b0);
      h = 0; v = 0;
      for (int i = 0; i < 6000; i++) begin
         if (h == 133 && v == 34) break;
         step(1'b1, (h == 0) && (v == 0));
      end
      tests++; if ({hs, vs, ucnt} !== {2'b11, 16'd5}) begin fails++; $display("FAIL t6_pre_reset: got %h want %h", {hs, vs, ucnt}, {2'b11, 16'd5}); end
      rst = 1'b1;
      step(1'b1, 1'b0);
      tests++; if ({de, hs, vs, fs, uf, rs, rgb, ucnt} !== 46'h0) begin fails++; $display("FAIL t6_reset_outputs: got %h want 0", {de, hs, vs, fs, uf, rs, rgb, ucnt}); end
      tests++; if (acc !== 1'b0) begin fails++; $display("FAIL t6_reset_ready: got %b want 0", acc); end
      rst = 1'b0; en = 1'b0;
      step(1'b0, 1'b0);
   endtask

   task automatic test_saturation;
      int pulses = 0;
      s_rst = 1'b1; s_en = 1'b0; s_pv = 1'b0; s_ps = 1'b0; s_pd = 24'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s_rst = 1'b0; s_en = 1'b1;
      @(posedge clk); #1;
      s_pv = 1'b1; s_ps = 1'b1; s_pd = 24'hABCDEF;
      #2;
      tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL sat_align_ready: got %b want 1", s_rdy); end
      @(posedge clk); #1;
      s_pv = 1'b0; s_ps = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         @(posedge clk); #1;
         pulses += int'(s_uf);
      end
      tests++; if (s_ucnt !== 16'd64515) begin fails++; $display("FAIL sat_frame1: got %0d want 64515", s_ucnt); end
      for (int i = 0; i < 8000; i++) begin
         if (pulses >= 70000) break;
         @(posedge clk); #1;
         pulses += int'(s_uf);
      end
      tests++; if (pulses != 70000) begin fails++; $display("FAIL sat_pulses: got %0d want 70000", pulses); end
      tests++; if (s_ucnt !== 16'hFFFF) begin fails++; $display("FAIL sat_count: got %h want ffff", s_ucnt); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pv = 1'b0; ps = 1'b0; pd = 24'h0;
      s_rst = 1'b1; s_en = 1'b0; s_pv = 1'b0; s_ps = 1'b0; s_pd = 24'h0;
      nd = 24'h123456; cd = 24'h0; acc = 1'b0;
      h = 0; v = 0; ph = -1; pvv = -1; npix = 0;
      @(posedge clk); #1;
      fork
         test_saturation();
         begin
            test_reset();
            test_stream();
            test_sof_search();
            test_underflow();
            test_resync();
            test_stop();
            test_reset_mid();
         end
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time exceeded, want summary before 1500000");
      $fatal(1, "timeout");
   end
endmodule
